// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_unit
//  Brief    : Single-issue fetch stage with jump flush, stall hold and halt.
//  Revision : 1.0
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [9:0]  RESET_PC     = 10'd0,
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter logic [31:0] NOP_WORD     = 32'b0110_1100_0000_0000_0000_0000_0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump_enable,
    input  logic [9:0]  jump_address,
    input  logic        halt,
    input  logic [31:0] iRAMOutput,
    output logic [9:0]  address,
    output logic [31:0] instruction,
    output logic [9:0]  instruction_pc,
    output logic        instruction_valid,
    output logic        halted
);

    localparam logic [9:0] LAST_PC = 10'(MEMORY_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [9:0]  pc, pc_next;
    logic [31:0] instr_next;
    logic [9:0]  instr_pc_next;
    logic        valid_next;

    logic [9:0]  pc_plus;
    logic [9:0]  jump_target;

    // Increment wraps only at the last RAM word, never at the 10-bit boundary.
    assign pc_plus     = (pc == LAST_PC) ? 10'd0 : pc + 10'd1;
    assign jump_target = 10'(32'(jump_address) % 32'(MEMORY_DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_RUN;
            pc                <= RESET_PC;
            instruction       <= NOP_WORD;
            instruction_pc    <= RESET_PC;
            instruction_valid <= 1'b0;
        end else begin
            state             <= state_next;
            pc                <= pc_next;
            instruction       <= instr_next;
            instruction_pc    <= instr_pc_next;
            instruction_valid <= valid_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = instruction;
        instr_pc_next = instruction_pc;
        valid_next    = instruction_valid;

        unique case (state)
            ST_RUN: begin
                if (jump_enable) begin
                    // One-cycle flush; instruction_pc keeps the last real fetch.
                    pc_next    = jump_target;
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                end else if (halt) begin
                    state_next = ST_HALTED;
                    instr_next = NOP_WORD;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    pc_next       = pc_plus;
                    instr_next    = iRAMOutput;
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign address = pc;
    assign halted  = (state == ST_HALTED);

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: program counter value loaded on reset.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 1024: instruction RAM word count; the PC wraps modulo this value.
REQ-003 SHALL have parameter NOP_WORD, default 32'b0110_1100_0000_0000_0000_0000_0000_0000: the bubble instruction word.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  holds PC and instruction outputs.
REQ-007 SHALL have port jump_enable  input  1  redirects fetch to jump_address.
REQ-008 SHALL have port jump_address  input  10  jump target word address.
REQ-009 SHALL have port halt  input  1  requests a permanent stop of fetch.
REQ-010 SHALL have port iRAMOutput  input  32  instruction RAM read data, combinational from address.
REQ-011 SHALL have port address  output  10  instruction RAM read address.
REQ-012 SHALL have port instruction  output  32  registered fetched instruction.
REQ-013 SHALL have port instruction_pc  output  10  address the instruction output was fetched from.
REQ-014 SHALL have port instruction_valid  output  1  instruction output is real, not a bubble.
REQ-015 SHALL have port halted  output  1  unit is in the HALTED state.

Function
REQ-016 SHALL hold an internal 10-bit PC register; address SHALL equal PC combinationally.
REQ-017 SHALL implement a two-state FSM: RUN and HALTED.
REQ-018 SHALL apply per-edge priority in RUN: reset > jump_enable > halt > stall > normal fetch.
REQ-019 On a normal fetch, SHALL latch instruction<=iRAMOutput, instruction_pc<=PC, and instruction_valid<=1, and SHALL set PC<=PC+1.
REQ-020 On a PC increment from MEMORY_DEPTH-1, SHALL set PC to 0; no other wrap behaviour.
REQ-021 On jump_enable, SHALL set PC<=jump_address mod MEMORY_DEPTH, instruction<=NOP_WORD, and instruction_valid<=0 (one-cycle flush), and SHALL keep instruction_pc unchanged.
REQ-022 On jump_enable together with stall or halt, SHALL take the jump; halt and stall are ignored that cycle.
REQ-023 On stall (no jump or halt), SHALL hold PC, instruction, instruction_pc, and instruction_valid unchanged.
REQ-024 On halt (no jump), SHALL enter HALTED and set instruction<=NOP_WORD, instruction_valid<=0, and halted<=1, and SHALL hold PC.
REQ-025 In HALTED, SHALL ignore stall, jump_enable, and halt; only reset SHALL leave HALTED.
REQ-026 Fetch latency SHALL be one cycle: the word at address A appears on instruction one edge after PC=A.

Reset
REQ-027 Reset SHALL set PC=RESET_PC, instruction=NOP_WORD, instruction_pc=RESET_PC, instruction_valid=0, halted=0, and state=RUN.
REQ-028 Reset asserted mid-stream, including in HALTED or during stall or jump, SHALL override all other inputs on that edge.
REQ-029 The first edge after reset deasserts SHALL perform a normal fetch from RESET_PC.

Verification
REQ-030 Bench SHALL check linear fetch: RAM word[i]=i+100, no stall -> the cycles after reset show instruction 100,101,102,... with instruction_pc 0,1,2,... and valid=1.
REQ-031 Bench SHALL check jump flush: jump_enable=1 with jump_address=40 while PC=5 -> next cycle instruction=NOP_WORD and valid=0; the following cycle instruction=word[40] and instruction_pc=40.
REQ-032 Bench SHALL check stall hold: stall=1 for 3 cycles at PC=7 -> address stays 7 and instruction/instruction_pc are unchanged; after release, word[7] is fetched once, with no skip or duplicate.
REQ-033 Bench SHALL check wrap: PC=1023, normal fetch -> instruction_pc=1023 and the next address is 0.
REQ-034 Bench SHALL check halt: halt=1 at PC=12 -> halted=1 and valid=0 from the next cycle, with PC held at 12 under subsequent jump_enable; reset then gives PC=0 and halted=0.
REQ-035 Bench SHALL check simultaneous events: jump_enable, halt, and stall all 1 -> jump taken and halted stays 0.
